double_to_int: RTL and testbench

- Converts an IEEE-754 binary64 operand to a signed 64-bit two's-complement integer.
- Multi-cycle state machine with stb/ack handshakes on both input and output.
- Complements the double-valued components such as double_neg: it consumes a double and produces an integer.
- Used wherever double results feed integer datapaths or file-based stimulus/response benches.

---
 rtl/double_to_int.sv | 213 +++++++++++++++++++++
 tb/tb_double_to_int.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/double_to_int.sv
// double_to_int: IEEE-754 binary64 -> signed 64-bit integer converter.
// stb/ack handshake on both sides, one operand in flight at a time.
// Default rounding truncates toward zero. Define DOUBLE_TO_INT_RNE_EN to
// round to nearest even (adds a ROUND state plus guard/sticky tracking).
module double_to_int (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    S_GET_A,
    S_UNPACK,
    S_ALIGN,
    S_ROUND,
    S_NEGATE,
    S_PUT_Z
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_a, w_a_nxt;
  logic        r_s, w_s_nxt;
  logic [63:0] r_m, w_m_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic [63:0] r_res, w_res_nxt;
  logic [63:0] r_z, w_z_nxt;
  logic        r_ack, w_ack_nxt;
  logic        r_stb, w_stb_nxt;

  // Operand field decode, only meaningful while in UNPACK.
  logic [10:0] w_exp;
  logic [11:0] w_e;
  logic [5:0]  w_cnt;
  logic [63:0] w_mant;
  logic        w_e_neg;
  logic        w_e_sat;

  assign w_exp   = r_a[62:52];
  assign w_e     = {1'b0, w_exp} - 12'd1023;
  // cnt is only used when 0 <= e <= 62, so the low 6 bits suffice.
  assign w_cnt   = 6'd63 - w_e[5:0];
  assign w_mant  = {1'b1, r_a[51:0], 11'b0};
  assign w_e_neg = w_e[11];
  assign w_e_sat = !w_e[11] && (w_e >= 12'd63);

`ifdef DOUBLE_TO_INT_RNE_EN
  logic        r_g, w_g_nxt;
  logic        r_st, w_st_nxt;
  logic        r_small, w_small_nxt;
  logic [63:0] w_m_rnd;
  // Round up only when past the halfway point, or exactly halfway and odd.
  assign w_m_rnd = r_m + {63'b0, r_g & (r_st | r_m[0])};
`endif

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_GET_A;
      r_a     <= '0;
      r_s     <= 1'b0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_z     <= '0;
      r_ack   <= 1'b0;
      r_stb   <= 1'b0;
`ifdef DOUBLE_TO_INT_RNE_EN
      r_g     <= 1'b0;
      r_st    <= 1'b0;
      r_small <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_s     <= w_s_nxt;
      r_m     <= w_m_nxt;
      r_cnt   <= w_cnt_nxt;
      r_res   <= w_res_nxt;
      r_z     <= w_z_nxt;
      r_ack   <= w_ack_nxt;
      r_stb   <= w_stb_nxt;
`ifdef DOUBLE_TO_INT_RNE_EN
      r_g     <= w_g_nxt;
      r_st    <= w_st_nxt;
      r_small <= w_small_nxt;
`endif
    end
  end

  // Next-state and next-datapath logic for the conversion sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_s_nxt     = r_s;
    w_m_nxt     = r_m;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_res;
    w_z_nxt     = r_z;
    w_ack_nxt   = r_ack;
    w_stb_nxt   = r_stb;
`ifdef DOUBLE_TO_INT_RNE_EN
    w_g_nxt     = r_g;
    w_st_nxt    = r_st;
    w_small_nxt = r_small;
`endif
    unique case (r_state)
      S_GET_A: begin
        w_ack_nxt = 1'b1;
        if (input_a_stb && r_ack) begin
          w_a_nxt     = input_a;
          w_ack_nxt   = 1'b0;
          w_state_nxt = S_UNPACK;
        end
      end
      S_UNPACK: begin
        w_s_nxt   = r_a[63];
        w_m_nxt   = w_mant;
        w_cnt_nxt = w_cnt;
`ifdef DOUBLE_TO_INT_RNE_EN
        w_g_nxt     = 1'b0;
        w_st_nxt    = 1'b0;
        w_small_nxt = 1'b0;
`endif
        if (w_exp == 11'h7FF) begin
          w_res_nxt   = 64'h8000_0000_0000_0000;
          w_state_nxt = S_PUT_Z;
        end else if (w_exp == 11'h000) begin
          w_res_nxt   = '0;
          w_state_nxt = S_PUT_Z;
        end else if (w_e_sat) begin
          // -2^63 lands here too and is exact.
          w_res_nxt   = 64'h8000_0000_0000_0000;
          w_state_nxt = S_PUT_Z;
        end else if (w_e_neg) begin
`ifdef DOUBLE_TO_INT_RNE_EN
          // |x| < 1: integer part is zero, only the rounding decision remains.
          w_m_nxt     = '0;
          w_small_nxt = 1'b1;
          w_g_nxt     = (w_e == 12'hFFF) ? w_mant[63] : 1'b0;
          w_st_nxt    = (w_e == 12'hFFF) ? |w_mant[62:0] : 1'b1;
          w_state_nxt = S_ROUND;
`else
          w_res_nxt   = '0;
          w_state_nxt = S_PUT_Z;
`endif
        end else begin
          w_state_nxt = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (r_cnt == 6'd0) begin
`ifdef DOUBLE_TO_INT_RNE_EN
          w_state_nxt = S_ROUND;
`else
          w_state_nxt = S_NEGATE;
`endif
        end else if (r_cnt >= 6'd8) begin
          w_m_nxt   = {8'b0, r_m[63:8]};
          w_cnt_nxt = r_cnt - 6'd8;
`ifdef DOUBLE_TO_INT_RNE_EN
          w_g_nxt  = r_m[7];
          w_st_nxt = r_st | r_g | (|r_m[6:0]);
`endif
        end else begin
          w_m_nxt   = {1'b0, r_m[63:1]};
          w_cnt_nxt = r_cnt - 6'd1;
`ifdef DOUBLE_TO_INT_RNE_EN
          w_g_nxt  = r_m[0];
          w_st_nxt = r_st | r_g;
`endif
        end
      end
`ifdef DOUBLE_TO_INT_RNE_EN
      S_ROUND: begin
        if (r_small) begin
          // Sub-unity operands skip NEGATE so they cost one extra cycle only.
          w_res_nxt   = r_s ? -w_m_rnd : w_m_rnd;
          w_state_nxt = S_PUT_Z;
        end else begin
          w_m_nxt     = w_m_rnd;
          w_state_nxt = S_NEGATE;
        end
      end
`endif
      S_NEGATE: begin
        // A magnitude of 2^63 negates to itself, giving the saturated code.
        w_res_nxt   = r_s ? -r_m : r_m;
        w_state_nxt = S_PUT_Z;
      end
      S_PUT_Z: begin
        w_z_nxt   = r_res;
        w_stb_nxt = 1'b1;
        if (r_stb && output_z_ack) begin
          w_stb_nxt   = 1'b0;
          w_state_nxt = S_GET_A;
        end
      end
      default: begin
        w_state_nxt = S_GET_A;
      end
    endcase
  end

  assign input_a_ack  = r_ack;
  assign output_z     = r_z;
  assign output_z_stb = r_stb;

endmodule

// File: tb/tb_double_to_int.sv
// tb_double_to_int: directed and randomized checks of double_to_int against
// an arithmetic reference model (mantissa scaled by a power of two).
module tb_double_to_int;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int n_chk  = 0;
  int n_fail = 0;

  double_to_int dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  // Reference: value = 1.mant * 2^e, reduced to an integer by plain division.
  function automatic logic [63:0] ref_conv(input logic [63:0] a);
    int          ex;
    int          e;
    int          sh;
    logic [63:0] mant;
    logic [63:0] q;
    ex = int'(a[62:52]);
    if (ex == 2047) return 64'h8000_0000_0000_0000;
    if (ex == 0) return 64'h0;
    e = ex - 1023;
    if (e >= 63) return 64'h8000_0000_0000_0000;
    mant = {11'b0, 1'b1, a[51:0]};
    if (e >= 52) begin
      q = mant << (e - 52);
    end else if (e >= -1) begin
      sh = 52 - e;
      q  = mant >> sh;
`ifdef DOUBLE_TO_INT_RNE_EN
      begin
        logic [63:0] rem;
        logic [63:0] half;
        rem  = mant - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      end
`endif
    end else begin
      q = 64'h0;
    end
    return a[63] ? -q : q;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operand; returns result and cycles from accept edge to stb.
  // Completes the output handshake only when output_z_ack is high.
  task automatic conv(input logic [63:0] a, output logic [63:0] z, output int lat);
    int n;
    @(negedge clk);
    input_a     = a;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {63'b0, input_a_ack}, 64'd1);
    @(posedge clk);
    #1 input_a_stb = 1'b0;
    lat = 0;
    while (!output_z_stb && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("z_stb", {63'b0, output_z_stb}, 64'd1);
    z = output_z;
    if (output_z_ack) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] dir_a [13];
    logic [63:0] dir_z [13];
    int          dir_lat [13];
    logic [63:0] z;
    logic [63:0] a;
    logic [63:0] r;
    logic [10:0] ex;
    int          lat;
    int          sel;
    bit          stb_seen;

    dir_a[0]  = 64'h3FF0_0000_0000_0000; dir_z[0]  = 64'h1;                   dir_lat[0]  = -1;
    dir_a[1]  = 64'hC004_0000_0000_0000; dir_z[1]  = 64'hFFFF_FFFF_FFFF_FFFE; dir_lat[1]  = -1;
`ifdef DOUBLE_TO_INT_RNE_EN
    dir_a[2]  = 64'h400C_0000_0000_0000; dir_z[2]  = 64'h4;                   dir_lat[2]  = -1;
    dir_a[3]  = 64'h3FE8_0000_0000_0000; dir_z[3]  = 64'h1;                   dir_lat[3]  = 3;
    dir_a[9]  = 64'h4330_0000_0000_0000; dir_z[9]  = 64'h0010_0000_0000_0000; dir_lat[9]  = 9;
`else
    dir_a[2]  = 64'h400C_0000_0000_0000; dir_z[2]  = 64'h3;                   dir_lat[2]  = -1;
    dir_a[3]  = 64'h3FE8_0000_0000_0000; dir_z[3]  = 64'h0;                   dir_lat[3]  = 2;
    dir_a[9]  = 64'h4330_0000_0000_0000; dir_z[9]  = 64'h0010_0000_0000_0000; dir_lat[9]  = 8;
`endif
    dir_a[4]  = 64'h7FF8_0000_0000_0000; dir_z[4]  = 64'h8000_0000_0000_0000; dir_lat[4]  = 2;
    dir_a[5]  = 64'h7FF0_0000_0000_0000; dir_z[5]  = 64'h8000_0000_0000_0000; dir_lat[5]  = 2;
    dir_a[6]  = 64'h43E0_0000_0000_0000; dir_z[6]  = 64'h8000_0000_0000_0000; dir_lat[6]  = 2;
    dir_a[7]  = 64'hC3E0_0000_0000_0000; dir_z[7]  = 64'h8000_0000_0000_0000; dir_lat[7]  = 2;
    dir_a[8]  = 64'h0000_0000_0000_0001; dir_z[8]  = 64'h0;                   dir_lat[8]  = 2;
    dir_a[10] = 64'hBFF0_0000_0000_0000; dir_z[10] = 64'hFFFF_FFFF_FFFF_FFFF; dir_lat[10] = -1;
    dir_a[11] = 64'h3FE0_0000_0000_0000; dir_z[11] = 64'h0;                   dir_lat[11] = -1;
    dir_a[12] = 64'h43DF_FFFF_FFFF_FFFF; dir_z[12] = 64'h7FFF_FFFF_FFFF_FC00; dir_lat[12] = -1;

    // Reset state.
    rst_n        = 1'b0;
    input_a      = '0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b1;
    #12;
    chk("rst_ack", {63'b0, input_a_ack}, 64'd0);
    chk("rst_stb", {63'b0, output_z_stb}, 64'd0);
    chk("rst_z", output_z, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ack", {63'b0, input_a_ack}, 64'd1);
    chk("rel_stb", {63'b0, output_z_stb}, 64'd0);
    chk("rel_z", output_z, 64'd0);

    // Directed values with known results and latencies.
    for (int i = 0; i < 13; i++) begin
      conv(dir_a[i], z, lat);
      chk($sformatf("dir%0d_z", i), z, dir_z[i]);
      if (dir_lat[i] >= 0) chk($sformatf("dir%0d_lat", i), 64'(lat), 64'(dir_lat[i]));
    end
    chk("z_hold", output_z, dir_z[12]);

    // Backpressure: result held, no new accept until the handshake.
    output_z_ack = 1'b0;
    conv(64'h400C_0000_0000_0000, z, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_stb", {63'b0, output_z_stb}, 64'd1);
      chk("bp_z", output_z, z);
      chk("bp_ack", {63'b0, input_a_ack}, 64'd0);
    end
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rel_stb", {63'b0, output_z_stb}, 64'd0);
    chk("bp_rel_ack", {63'b0, input_a_ack}, 64'd0);
    @(posedge clk);
    #1;
    chk("bp_next_ack", {63'b0, input_a_ack}, 64'd1);

    // Reset while aligning 1.0e18: operand abandoned, outputs cleared.
    @(negedge clk);
    input_a     = 64'h43AB_C16D_674E_C800;
    input_a_stb = 1'b1;
    @(posedge clk);
    #1 input_a_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", {63'b0, input_a_ack}, 64'd0);
    chk("mid_rst_stb", {63'b0, output_z_stb}, 64'd0);
    chk("mid_rst_z", output_z, 64'd0);
    stb_seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 stb_seen = stb_seen | output_z_stb;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1 stb_seen = stb_seen | output_z_stb;
    end
    chk("mid_rst_no_out", {63'b0, stb_seen}, 64'd0);
    conv(64'h4045_0000_0000_0000, z, lat);
    chk("after_rst_42", z, 64'h2A);

    // Randomized operands against the reference model.
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 11));
      if (sel == 0) ex = 11'h000;
      else if (sel == 1) ex = 11'h7FF;
      else ex = 11'($urandom_range(1018, 1088));
      r = {$urandom, $urandom};
      a = {r[63], ex, r[51:0]};
      conv(a, z, lat);
      chk($sformatf("rand%0d_%h", i, a), z, ref_conv(a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
